// File: rtl/clk_gen_multi_if.sv
// Divider-channel write bus for clk_gen_multi: one strobe selects a channel and
// supplies its next divide value.
interface clk_gen_multi_if #(
    parameter int SEL_W = 2,
    parameter int DIV_W = 16
);
    // Handshake: div_we is a single-cycle write strobe (the valid). There is no
    // ready; the slave always takes the write on the edge that samples div_we=1,
    // so div_sel/div_val only need to be stable while div_we is high.
    logic             div_we;
    logic [SEL_W-1:0] div_sel;
    logic [DIV_W-1:0] div_val;

    modport master (output div_we, div_sel, div_val);
    modport slave  (input  div_we, div_sel, div_val);
endinterface

// File: rtl/clk_gen_multi.sv
// Board clock generator on clk200m: free-running divide bus, programmable enable/square
// channels, and a glitch-free CPU clock with fast/slow/single-step/stop modes.
module clk_gen_multi #(
    parameter int               CNT_W    = 32,
    parameter int               N_CH     = 4,
    parameter int               SEL_W    = 2,
    parameter int               DIV_W    = 16,
    parameter logic [DIV_W-1:0] DIV_INIT = 16'd99,
    parameter int               FAST_BIT = 1,
    parameter int               SLOW_BIT = 24,
    parameter logic [19:0]      DEB_CYC  = 20'd1000000,
    parameter logic [7:0]       STEP_HI  = 8'd4,
    parameter logic [7:0]       STEP_LO  = 8'd4
) (
    input  logic              clk200m,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              step_btn,
    clk_gen_multi_if.slave    div_bus,
    output logic [CNT_W-1:0]  clkdiv,
    output logic [N_CH-1:0]   ch_ce,
    output logic [N_CH-1:0]   ch_clk,
    output logic              cpu_clk,
    output logic              step_busy,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SYNC      = 3'd1,
        ST_STEP_IDLE = 3'd2,
        ST_STEP_HI   = 3'd3,
        ST_STEP_LO   = 3'd4,
        ST_STOP      = 3'd5
    } state_t;

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) clkdiv <= '0;
        else     clkdiv <= clkdiv + 1'b1;
    end

    logic [N_CH-1:0][DIV_W-1:0] ch_cnt;
    logic [N_CH-1:0][DIV_W-1:0] div_act;
    logic [N_CH-1:0][DIV_W-1:0] div_pend;

    // A new divide value waits in div_pend and is only adopted at terminal count,
    // so a running period is never truncated.
    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            ch_cnt   <= '0;
            div_act  <= {N_CH{DIV_INIT}};
            div_pend <= {N_CH{DIV_INIT}};
            ch_ce    <= '0;
            ch_clk   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (div_bus.div_we && div_bus.div_sel == SEL_W'(i))
                    div_pend[i] <= div_bus.div_val;
                if (ch_cnt[i] == div_act[i]) begin
                    ch_cnt[i]  <= '0;
                    ch_ce[i]   <= 1'b1;
                    ch_clk[i]  <= ~ch_clk[i];
                    div_act[i] <= div_pend[i];
                end else begin
                    ch_cnt[i]  <= ch_cnt[i] + 1'b1;
                    ch_ce[i]   <= 1'b0;
                end
            end
        end
    end

    logic        btn_s1, btn_s2, deb_lvl, step_req;
    logic [19:0] deb_cnt;

    // Only a debounced 0->1 transition produces a step request.
    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            deb_lvl  <= 1'b0;
            deb_cnt  <= '0;
            step_req <= 1'b0;
        end else begin
            btn_s1   <= step_btn;
            btn_s2   <= btn_s1;
            step_req <= 1'b0;
            if (btn_s2 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_CYC - 20'd1) begin
                deb_cnt  <= '0;
                deb_lvl  <= btn_s2;
                step_req <= btn_s2;
            end else begin
                deb_cnt <= deb_cnt + 20'd1;
            end
        end
    end

    state_t     state, state_nxt;
    logic [1:0] mode_req, mode_act, mode_act_nxt;
    logic       seen_low, seen_low_nxt;
    logic [7:0] step_cnt, step_cnt_nxt;
    logic       sel_bit, cpu_clk_nxt, step_busy_nxt;

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            state     <= ST_SYNC;
            mode_req  <= 2'd3;
            mode_act  <= 2'd3;
            seen_low  <= 1'b0;
            step_cnt  <= '0;
            cpu_clk   <= 1'b0;
            step_busy <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_req  <= mode;
            mode_act  <= mode_act_nxt;
            seen_low  <= seen_low_nxt;
            step_cnt  <= step_cnt_nxt;
            cpu_clk   <= cpu_clk_nxt;
            step_busy <= step_busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mode_act_nxt = mode_act;
        seen_low_nxt = seen_low;
        step_cnt_nxt = step_cnt;
        sel_bit      = mode_act[0] ? clkdiv[SLOW_BIT] : clkdiv[FAST_BIT];
        // Mode switches happen only while cpu_clk is low and never mid-step-pulse.
        if (!cpu_clk && state != ST_STEP_HI && mode_req != mode_act) begin
            mode_act_nxt = mode_req;
            seen_low_nxt = 1'b0;
            step_cnt_nxt = '0;
            case (mode_req)
                2'd0, 2'd1: state_nxt = ST_SYNC;
                2'd2:       state_nxt = ST_STEP_IDLE;
                default:    state_nxt = ST_STOP;
            endcase
        end else begin
            case (state)
                ST_SYNC: begin
                    if (mode_act[1])
                        state_nxt = mode_act[0] ? ST_STOP : ST_STEP_IDLE;
                    else if (!seen_low) begin
                        if (!sel_bit) seen_low_nxt = 1'b1;
                    end else if (sel_bit)
                        state_nxt = ST_RUN;
                end
                ST_STEP_IDLE: begin
                    if (step_req) begin
                        state_nxt    = ST_STEP_HI;
                        step_cnt_nxt = '0;
                    end
                end
                ST_STEP_HI: begin
                    if (step_cnt == STEP_HI - 8'd1) begin
                        state_nxt    = ST_STEP_LO;
                        step_cnt_nxt = '0;
                    end else begin
                        step_cnt_nxt = step_cnt + 8'd1;
                    end
                end
                ST_STEP_LO: begin
                    if (step_cnt == STEP_LO - 8'd1) begin
                        state_nxt    = ST_STEP_IDLE;
                        step_cnt_nxt = '0;
                    end else begin
                        step_cnt_nxt = step_cnt + 8'd1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
        cpu_clk_nxt   = (state_nxt == ST_RUN) ? sel_bit : (state_nxt == ST_STEP_HI);
        step_busy_nxt = (state_nxt == ST_STEP_HI) || (state_nxt == ST_STEP_LO);
    end

    assign state_dbg = state;

endmodule
